hs_channel_arbiter: RTL and testbench

Round-robin arbiter sharing one cross-domain req/ack data channel among N_REQ requesters in the clk_a domain. Latches the winning requester's word, raises data_req to the far-side receiver, and waits for the receiver's acknowledge, resynchronised locally. Enforces a minimum idle gap between transfers and aborts with an error on a timeout. Sits between the clk_a-side producers and the channel that feeds the clk_b-side receiver.

---
 rtl/hs_channel_arbiter.sv | 129 ++++++++++++
 tb/tb_hs_channel_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hs_channel_arbiter.sv
// Round-robin arbiter that shares one req/ack channel among N_REQ clk_a-side requesters.
// The far-side acknowledge is resynchronised locally. A minimum idle gap is enforced, and a timeout aborts a transfer.
module hs_channel_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 4,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_a,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      src_valid,
    input  logic [N_REQ*DW-1:0]   src_data,
    output logic [N_REQ-1:0]      src_grant,
    output logic [N_REQ-1:0]      src_done,
    output logic [N_REQ-1:0]      src_err,
    output logic [DW-1:0]         data,
    output logic                  data_req,
    input  logic                  data_ack,
    output logic                  busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q, w_q;
    logic [7:0]        to_cnt_q;
    logic [3:0]        gap_cnt_q;
    logic              ack_s1_q, ack_s2_q;
    logic [DW-1:0]     data_q;
    logic              data_req_q, busy_q;
    logic [N_REQ-1:0]  grant_q, done_q, err_q;

    logic              win_found_d;
    logic [PW-1:0]     win_idx_d;
    logic [DW-1:0]     win_word_d;
    int                cand;

    wire ack_rise  = ack_s1_q & ~ack_s2_q;
    wire timed_out = (to_cnt_q == 8'(TIMEOUT));

    // First valid requester at or above ptr, wrapping.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        win_word_d  = '0;
        cand        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!win_found_d && src_valid[PW'(cand)]) begin
                win_found_d = 1'b1;
                win_idx_d   = PW'(cand);
            end
        end
        for (int k = 0; k < N_REQ; k++)
            if (win_idx_d == PW'(k)) win_word_d = src_data[k*DW +: DW];
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            w_q        <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            ack_s1_q   <= 1'b0;
            ack_s2_q   <= 1'b0;
            data_q     <= '0;
            data_req_q <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            ack_s1_q <= data_ack;
            ack_s2_q <= ack_s1_q;
            done_q   <= '0;
            err_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_found_d) begin
                        data_q     <= win_word_d;
                        data_req_q <= 1'b1;
                        grant_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_d;
                        w_q        <= win_idx_d;
                        to_cnt_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    to_cnt_q <= to_cnt_q + 8'd1;
                    // An ack landing on the timeout cycle still counts as success.
                    if (ack_rise || timed_out) begin
                        data_req_q <= 1'b0;
                        data_q     <= '0;
                        grant_q    <= '0;
                        if (ack_rise) done_q[w_q] <= 1'b1;
                        else          err_q[w_q]  <= 1'b1;
                        ptr_q      <= (w_q == PW'(N_REQ-1)) ? '0 : w_q + 1'b1;
                        gap_cnt_q  <= '0;
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    // A stuck-high ack holds us here until it drops.
                    if (gap_cnt_q == 4'(GAP-1) && !ack_s2_q) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (gap_cnt_q != 4'(GAP-1)) begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign src_grant = grant_q;
    assign src_done  = done_q;
    assign src_err   = err_q;
    assign data      = data_q;
    assign data_req  = data_req_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_hs_channel_arbiter.sv
// Scoreboard bench for hs_channel_arbiter: stimulus queues expected transfers, monitor checks each one on the channel.
module tb_hs_channel_arbiter;
    localparam int N = 4, DW = 4, GAP = 4, TMO = 10;

    logic            clk_a = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_grant, src_done, src_err;
    logic [DW-1:0]   data;
    logic            data_req, data_ack, busy;

    hs_channel_arbiter #(.N_REQ(N), .DW(DW), .GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk_a(clk_a), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .src_grant(src_grant), .src_done(src_done), .src_err(src_err),
        .data(data), .data_req(data_req), .data_ack(data_ack), .busy(busy)
    );

    always #5 clk_a = ~clk_a;

    typedef struct {
        int w;
        int word;
        bit is_err;
        int len;
        int gap_after;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   mptr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++)
            if (m[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Monitor: compares every channel transfer against the front of the queue.
    initial begin : mon
        bit   prev_req = 0, inflight = 0;
        int   len = 0, low = 0, exp_gap = 0;
        exp_t cur;
        forever begin
            @(negedge clk_a);
            if (!rst_n) begin
                prev_req = 0; inflight = 0; len = 0; low = 0; exp_gap = 0;
                continue;
            end
            if (data_req && !prev_req) begin
                if (q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    cur = q[0];
                    inflight = 1;
                    if (exp_gap != 0) chk("gap_len", low, exp_gap);
                    chk("busy_at_req", int'(busy), 1);
                end
                len = 0;
            end
            if (data_req) begin
                len++;
                if (inflight) begin
                    chk("data", int'(data), cur.word);
                    chk("grant", int'(src_grant), 1 << cur.w);
                end
            end
            if (!data_req && prev_req) begin
                if (inflight) begin
                    chk("done", int'(src_done), cur.is_err ? 0 : (1 << cur.w));
                    chk("err", int'(src_err), cur.is_err ? (1 << cur.w) : 0);
                    chk("req_len", len, cur.len);
                    chk("data_cleared", int'(data), 0);
                    chk("grant_cleared", int'(src_grant), 0);
                    exp_gap = cur.gap_after;
                    void'(q.pop_front());
                    inflight = 0;
                end
                low = 0;
            end else if ((src_done | src_err) != 0) begin
                chk("spurious_pulse", int'(src_done | src_err), 0);
            end
            if (!data_req) low++;
            prev_req = data_req;
        end
    end

    // One transfer using the mask already on src_valid; next_mask is applied once it completes.
    task automatic txn(input logic [N-1:0] next_mask, input int d, input bit tmo, input int hold);
        exp_t e;
        int   w, t;
        w           = rr_pick(src_valid, mptr);
        e.w         = w;
        e.word      = int'(src_data[w*DW +: DW]);
        e.is_err    = tmo;
        e.len       = tmo ? TMO + 1 : d + 2;
        e.gap_after = (next_mask == 0) ? 0 : ((hold + 4 > GAP + 1) ? hold + 4 : GAP + 1);
        mptr        = (w + 1) % N;
        q.push_back(e);
        t = 0;
        do begin @(negedge clk_a); t++; end while (!data_req && t < 40);
        if (!data_req) begin chk("grant_wait", 0, 1); finish_run(); end
        src_data = $urandom;
        if ($urandom_range(1, 0) == 1) src_valid = src_valid & N'($urandom);
        if (!tmo) begin
            repeat (d) @(negedge clk_a);
            data_ack = 1'b1;
        end
        t = 0;
        while ((src_done | src_err) == 0 && t < 60) begin @(negedge clk_a); t++; end
        if ((src_done | src_err) == 0) begin chk("done_wait", 0, 1); finish_run(); end
        src_valid = next_mask;
        src_data  = $urandom;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_a);
            chk("busy_hold", int'(busy), 1);
        end
        data_ack = 1'b0;
    endtask

    initial begin : stim
        logic [N-1:0] nm;
        bit           tmo;
        int           t;
        exp_t         e;
        rst_n = 1'b0; src_valid = '0; src_data = '0; data_ack = 1'b0;
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_req", int'(data_req), 0);
        chk("rst_grant", int'(src_grant), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk_a);
        rst_n = 1'b1;
        src_valid = 4'b0001; src_data = 16'h0005;
        txn(4'b0010, 3, 0, 0);                      // single requester, ptr -> 1
        txn(4'b1001, 2, 0, 0);                      // ptr -> 2
        src_data = 16'h4321;
        txn(4'b1111, 1, 0, 0);                      // 3 before 0
        src_data = 16'h4321;
        for (int i = 0; i < 5; i++) txn(4'b1111, i, 0, 0);
        txn(4'b1111, 0, 1, 0);                      // timeout
        txn(4'b1111, 9, 0, 0);                      // ack on the timeout edge
        txn(4'b0110, 2, 0, 6);                      // stuck-high ack
        for (int i = 0; i < 40; i++) begin
            nm  = N'($urandom_range(15, 1));
            tmo = ($urandom_range(5, 0) == 0);
            txn(nm, $urandom_range(9, 0), tmo, tmo ? 0 : $urandom_range(5, 0));
        end
        txn(4'b0100, 1, 0, 0);
        // Reset in the middle of a transfer.
        e.w = rr_pick(src_valid, mptr); e.word = int'(src_data[e.w*DW +: DW]);
        e.is_err = 0; e.len = 0; e.gap_after = 0;
        q.push_back(e);
        t = 0;
        do begin @(negedge clk_a); t++; end while (!data_req && t < 40);
        if (!data_req) begin chk("grant_wait", 0, 1); finish_run(); end
        @(negedge clk_a);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", int'(data), 0);
        chk("mid_rst_req", int'(data_req), 0);
        chk("mid_rst_grant", int'(src_grant), 0);
        chk("mid_rst_pulses", int'(src_done | src_err), 0);
        chk("mid_rst_busy", int'(busy), 0);
        q.delete();
        mptr = 0;
        src_valid = 4'b1001; src_data = $urandom;
        repeat (2) @(negedge clk_a);
        rst_n = 1'b1;
        txn(4'b0000, 2, 0, 0);                      // requester 0 first after reset
        repeat (12) @(negedge clk_a);
        chk("queue_empty", q.size(), 0);
        chk("idle_busy", int'(busy), 0);
        finish_run();
    end
endmodule
